// File: rtl/intel8254_bus_master.sv
// Host-side bus master for an 8254 timer: turns byte, word and latched-read
// commands into timed cs_n/rd_n/wr_n cycles on the chip's 8-bit bus.
module intel8254_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [1:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic        cs_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        a1,
    output logic        a0,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER,
        RESP
    } state_t;

    localparam logic [1:0] OP_WR_BYTE = 2'b00;
    localparam logic [1:0] OP_RD_BYTE = 2'b01;
    localparam logic [1:0] OP_WR_WORD = 2'b10;
    localparam logic [1:0] OP_RD_LATCH = 2'b11;
    localparam logic [1:0] CTRL_ADDR  = 2'd3;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic [1:0]  byte_idx;
    logic [1:0]  op_q;
    logic [1:0]  addr_q;
    logic [15:0] wdata_q;
    logic [7:0]  lsb_q;
    logic [7:0]  msb_q;
    logic [15:0] rsp_rdata_q;
    logic        rsp_error_q;

    logic        accept;
    logic        req_bad;
    logic        bus_active;
    logic        cur_write;
    logic [1:0]  cur_addr;
    logic [7:0]  cur_data;
    logic [1:0]  last_idx;
    logic        strobe_last;

    assign accept      = req_valid && (state == IDLE);
    assign req_bad     = (req_op != OP_WR_BYTE) && (req_addr == CTRL_ADDR);
    assign bus_active  = (state == SETUP) || (state == STROBE) || (state == HOLD);
    assign strobe_last = (state == STROBE) && (cnt == 4'd0);

    // Per-byte descriptor: a latched read starts with a counter-latch control
    // write selecting the counter, then reads LSB and MSB from that counter.
    always_comb begin
        cur_write = 1'b1;
        cur_addr  = addr_q;
        cur_data  = wdata_q[7:0];
        last_idx  = 2'd0;
        case (op_q)
            OP_WR_BYTE: cur_write = 1'b1;
            OP_RD_BYTE: cur_write = 1'b0;
            OP_WR_WORD: begin
                last_idx = 2'd1;
                if (byte_idx == 2'd1) begin
                    cur_data = wdata_q[15:8];
                end
            end
            default: begin
                last_idx = 2'd2;
                if (byte_idx == 2'd0) begin
                    cur_addr = CTRL_ADDR;
                    cur_data = {addr_q, 6'b000000};
                end else begin
                    cur_write = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = req_bad ? RESP : SETUP;
                end
            end
            SETUP:   if (cnt == 4'd0) next_state = STROBE;
            STROBE:  if (cnt == 4'd0) next_state = HOLD;
            HOLD:    if (cnt == 4'd0) next_state = RECOVER;
            RECOVER: next_state = (byte_idx == last_idx) ? RESP : SETUP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Dwell counter is reloaded on every state change and counts down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (next_state != state) begin
            case (next_state)
                SETUP:   cnt <= SETUP_LD;
                STROBE:  cnt <= STROBE_LD;
                HOLD:    cnt <= HOLD_LD;
                default: cnt <= 4'd0;
            endcase
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= 2'b00;
            addr_q   <= 2'b00;
            wdata_q  <= 16'h0000;
            byte_idx <= 2'd0;
        end else if (accept) begin
            op_q     <= req_op;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            byte_idx <= 2'd0;
        end else if ((state == RECOVER) && (next_state == SETUP)) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Read data is taken at the end of the strobe, when the chip has settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsb_q <= 8'h00;
            msb_q <= 8'h00;
        end else if (strobe_last && !cur_write) begin
            if (byte_idx == 2'd2) begin
                msb_q <= data_in;
            end else begin
                lsb_q <= data_in;
            end
        end
    end

    // Response fields load only on entry to RESP and hold until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata_q <= 16'h0000;
            rsp_error_q <= 1'b0;
        end else if ((next_state == RESP) && (state != RESP)) begin
            rsp_error_q <= (state == IDLE);
            if (state == IDLE) begin
                rsp_rdata_q <= 16'h0000;
            end else if (op_q == OP_RD_BYTE) begin
                rsp_rdata_q <= {8'h00, lsb_q};
            end else if (op_q == OP_RD_LATCH) begin
                rsp_rdata_q <= {msb_q, lsb_q};
            end else begin
                rsp_rdata_q <= 16'h0000;
            end
        end
    end

    // Bus outputs decode straight from state so reset releases them at once.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        cs_n      = !bus_active;
        wr_n      = !((state == STROBE) && cur_write);
        rd_n      = !((state == STROBE) && !cur_write);
        a1        = bus_active ? cur_addr[1] : 1'b0;
        a0        = bus_active ? cur_addr[0] : 1'b0;
        data_oe   = bus_active && cur_write;
        data_out  = (bus_active && cur_write) ? cur_data : 8'h00;
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_intel8254_bus_master.sv
// Directed bench for intel8254_bus_master: default-timing instance plus a
// slow-timing instance for the continuous-request scenario.
module tb_intel8254_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [1:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic        cs_n, rd_n, wr_n, a1, a0;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in;

    logic        req_valid2;
    logic        req_ready2;
    logic [1:0]  req_op2;
    logic [1:0]  req_addr2;
    logic [15:0] req_wdata2;
    logic        rsp_valid2;
    logic [15:0] rsp_rdata2;
    logic        rsp_error2;
    logic        cs_n2, rd_n2, wr_n2, a1_2, a0_2;
    logic [7:0]  data_out2;
    logic        data_oe2;
    logic [7:0]  data_in2;

    int checks = 0;
    int errors = 0;

    logic [9:0]  wq[$];
    logic [1:0]  rq[$];
    logic        prev_wr = 1'b1;
    logic        prev_rd = 1'b1;
    int          overlap = 0;
    int          overlap2 = 0;
    int          oe_bad = 0;
    int          rd_cnt = 0;
    int          rd_base = 0;
    logic [7:0]  rd_vals[2];
    logic [31:0] cs_tr, wr_tr, rd_tr, oe_tr;

    always #5 clk = ~clk;

    intel8254_bus_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a1(a1), .a0(a0),
        .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
    );

    intel8254_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_op(req_op2),
        .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_error(rsp_error2),
        .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2), .a1(a1_2), .a0(a0_2),
        .data_out(data_out2), .data_oe(data_oe2), .data_in(data_in2)
    );

    // Chip model: first read of a command returns rd_vals[0], later ones rd_vals[1].
    assign data_in  = ((rd_cnt - rd_base) >= 1) ? rd_vals[1] : rd_vals[0];
    assign data_in2 = 8'h00;

    always @(posedge rd_n) rd_cnt++;

    always @(negedge clk) begin
        if (!wr_n && prev_wr) wq.push_back({a1, a0, data_out});
        if (!rd_n && prev_rd) rq.push_back({a1, a0});
        if (!rd_n && !wr_n) overlap++;
        if ((!wr_n && !data_oe) || (!rd_n && data_oe)) oe_bad++;
        if (!rd_n2 && !wr_n2) overlap2++;
        prev_wr = wr_n;
        prev_rd = rd_n;
    end

    task automatic run_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [15:0] wd,
                           output int lat, output logic [15:0] rdat, output logic err);
        lat = 0;
        rdat = 16'h0000;
        err = 1'b0;
        cs_tr = '1; wr_tr = '1; rd_tr = '1; oe_tr = '0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_addr = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c < 32) begin
                cs_tr[c] = cs_n;
                wr_tr[c] = wr_n;
                rd_tr[c] = rd_n;
                oe_tr[c] = data_oe;
            end
            if (rsp_valid) begin
                lat = c;
                rdat = rsp_rdata;
                err = rsp_error;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, cs_n, rd_n, wr_n, a1, a0, data_oe, rsp_valid, rsp_error} !== 9'b111100000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 111100000",
                     {req_ready, cs_n, rd_n, wr_n, a1, a0, data_oe, rsp_valid, rsp_error});
        end
        checks++;
        if ({data_out, rsp_rdata} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_data got %h want 000000", {data_out, rsp_rdata});
        end
        rst = 1'b0;
    endtask

    task automatic test_byte_write();
        int lat; logic [15:0] rdat; logic err; int b;
        b = wq.size();
        run_cmd(2'b00, 2'd3, 16'h0034, lat, rdat, err);
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL bw_latency got %0d want 6", lat); end
        checks++;
        if ({err, rdat} !== 17'h0) begin errors++; $display("FAIL bw_rsp got %b/%h want 0/0000", err, rdat); end
        checks++;
        if (cs_tr[6:1] !== 6'b110000) begin errors++; $display("FAIL bw_cs got %b want 110000", cs_tr[6:1]); end
        checks++;
        if (wr_tr[6:1] !== 6'b111001) begin errors++; $display("FAIL bw_wr got %b want 111001", wr_tr[6:1]); end
        checks++;
        if (oe_tr[6:1] !== 6'b001111) begin errors++; $display("FAIL bw_oe got %b want 001111", oe_tr[6:1]); end
        checks++;
        if (rd_tr[6:1] !== 6'b111111) begin errors++; $display("FAIL bw_rd got %b want 111111", rd_tr[6:1]); end
        checks++;
        if (wq.size() != b + 1 || wq[b] !== {2'd3, 8'h34}) begin
            errors++;
            $display("FAIL bw_bytes got n=%0d want n=1 {3,34}", wq.size() - b);
        end
    endtask

    task automatic test_word_write();
        int lat; logic [15:0] rdat; logic err; int b;
        b = wq.size();
        run_cmd(2'b10, 2'd0, 16'h1234, lat, rdat, err);
        checks++;
        if (lat !== 11) begin errors++; $display("FAIL ww_latency got %0d want 11", lat); end
        checks++;
        if (cs_tr[11:1] !== 11'b11000010000) begin
            errors++;
            $display("FAIL ww_cs got %b want 11000010000", cs_tr[11:1]);
        end
        checks++;
        if (wq.size() != b + 2 || wq[b] !== {2'd0, 8'h34} || wq[b+1] !== {2'd0, 8'h12}) begin
            errors++;
            $display("FAIL ww_bytes got n=%0d want n=2 {0,34},{0,12}", wq.size() - b);
        end
        checks++;
        if ({err, rdat} !== 17'h0) begin errors++; $display("FAIL ww_rsp got %b/%h want 0/0000", err, rdat); end
    endtask

    task automatic test_single_read();
        int lat; logic [15:0] rdat; logic err; int b;
        rd_vals[0] = 8'h5A;
        rd_vals[1] = 8'hEE;
        rd_base = rd_cnt;
        b = rq.size();
        run_cmd(2'b01, 2'd1, 16'hFFFF, lat, rdat, err);
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL rd_latency got %0d want 6", lat); end
        checks++;
        if ({err, rdat} !== {1'b0, 16'h005A}) begin errors++; $display("FAIL rd_rsp got %b/%h want 0/005a", err, rdat); end
        checks++;
        if (rd_tr[6:1] !== 6'b111001 || wr_tr[6:1] !== 6'b111111 || oe_tr[6:1] !== 6'b000000) begin
            errors++;
            $display("FAIL rd_strobes got rd=%b wr=%b oe=%b want 111001/111111/000000", rd_tr[6:1], wr_tr[6:1], oe_tr[6:1]);
        end
        checks++;
        if (rq.size() != b + 1 || rq[b] !== 2'd1) begin
            errors++;
            $display("FAIL rd_addr got n=%0d want n=1 addr 1", rq.size() - b);
        end
    endtask

    task automatic test_latched_read();
        int lat; logic [15:0] rdat; logic err; int bw; int br;
        rd_vals[0] = 8'hCD;
        rd_vals[1] = 8'hAB;
        rd_base = rd_cnt;
        bw = wq.size();
        br = rq.size();
        run_cmd(2'b11, 2'd2, 16'h0000, lat, rdat, err);
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL lr_latency got %0d want 16", lat); end
        checks++;
        if ({err, rdat} !== {1'b0, 16'hABCD}) begin errors++; $display("FAIL lr_rsp got %b/%h want 0/abcd", err, rdat); end
        checks++;
        if (wq.size() != bw + 1 || wq[bw] !== {2'd3, 8'h80}) begin
            errors++;
            $display("FAIL lr_ctrl got n=%0d want n=1 {3,80}", wq.size() - bw);
        end
        checks++;
        if (rq.size() != br + 2 || rq[br] !== 2'd2 || rq[br+1] !== 2'd2) begin
            errors++;
            $display("FAIL lr_reads got n=%0d want n=2 addr 2", rq.size() - br);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b0, 16'hABCD}) begin
            errors++;
            $display("FAIL lr_hold got %b/%h want 0/abcd", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_error();
        int lat; logic [15:0] rdat; logic err; int bw; int br;
        logic [1:0] ops[3];
        ops[0] = 2'b01; ops[1] = 2'b10; ops[2] = 2'b11;
        bw = wq.size();
        br = rq.size();
        for (int i = 0; i < 3; i++) begin
            run_cmd(ops[i], 2'd3, 16'hA5A5, lat, rdat, err);
            checks++;
            if (lat !== 1 || err !== 1'b1 || rdat !== 16'h0000) begin
                errors++;
                $display("FAIL err_op%0d got lat=%0d err=%b data=%h want 1/1/0000", i + 1, lat, err, rdat);
            end
            checks++;
            if (cs_tr[1] !== 1'b1) begin errors++; $display("FAIL err_cs%0d got %b want 1", i + 1, cs_tr[1]); end
        end
        checks++;
        if (wq.size() != bw || rq.size() != br) begin
            errors++;
            $display("FAIL err_bus got writes=%0d reads=%0d want 0/0", wq.size() - bw, rq.size() - br);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_error !== 1'b1) begin errors++; $display("FAIL err_hold got %b want 1", rsp_error); end
    endtask

    task automatic test_reset_abort();
        int lat; logic [15:0] rdat; logic err; int b; int seen; int pulses;
        seen = 0;
        pulses = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_addr = 2'd0; req_wdata = 16'hBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!wr_n) begin seen = 1; break; end
        end
        checks++;
        if (seen != 1) begin errors++; $display("FAIL abort_strobe got no wr_n want wr_n low"); end
        rst = 1'b1;
        #1;
        checks++;
        if ({cs_n, wr_n, rd_n, data_oe} !== 4'b1110) begin
            errors++;
            $display("FAIL abort_release got %b want 1110", {cs_n, wr_n, rd_n, data_oe});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL abort_rsp got %0d pulses want 0", pulses); end
        b = wq.size();
        run_cmd(2'b00, 2'd1, 16'h0077, lat, rdat, err);
        checks++;
        if (lat !== 6 || err !== 1'b0 || wq.size() != b + 1 || wq[b] !== {2'd1, 8'h77}) begin
            errors++;
            $display("FAIL abort_next got lat=%0d err=%b n=%0d want 6/0/1", lat, err, wq.size() - b);
        end
    endtask

    task automatic test_back_to_back();
        int first; int second; int cs_low; int wr_low; int rdy; int accepts;
        first = 0; second = 0; cs_low = 0; wr_low = 0; rdy = 0; accepts = 0;
        @(negedge clk);
        req_op2 = 2'b00; req_addr2 = 2'd1; req_wdata2 = 16'h0055;
        req_valid2 = 1'b1;
        if (req_ready2) accepts++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c <= 11 && !cs_n2) cs_low++;
            if (c <= 11 && !wr_n2) wr_low++;
            if (c <= 10 && req_ready2) rdy++;
            if (req_ready2 && req_valid2) accepts++;
            if (rsp_valid2) begin
                if (first == 0) first = c;
                else if (second == 0) second = c;
            end
        end
        req_valid2 = 1'b0;
        checks++;
        if (first != 11 || second != 23) begin
            errors++;
            $display("FAIL b2b_rsp got %0d,%0d want 11,23", first, second);
        end
        checks++;
        if (cs_low != 9 || wr_low != 4) begin
            errors++;
            $display("FAIL b2b_dwell got cs=%0d wr=%0d want 9/4", cs_low, wr_low);
        end
        checks++;
        if (rdy != 0 || accepts != 4) begin
            errors++;
            $display("FAIL b2b_accept got busy_ready=%0d accepts=%0d want 0/4", rdy, accepts);
        end
        checks++;
        if (overlap != 0 || overlap2 != 0 || oe_bad != 0) begin
            errors++;
            $display("FAIL strobe_overlap got %0d/%0d/%0d want 0/0/0", overlap, overlap2, oe_bad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        req_valid = 1'b0; req_op = 2'b00; req_addr = 2'd0; req_wdata = 16'h0;
        req_valid2 = 1'b0; req_op2 = 2'b00; req_addr2 = 2'd0; req_wdata2 = 16'h0;
        rd_vals[0] = 8'h00;
        rd_vals[1] = 8'h00;
        test_reset();
        test_byte_write();
        test_word_write();
        test_single_read();
        test_latched_read();
        test_error();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intel8254_bus_master.md
INTEL8254_BUS_MASTER -- requirements
Module: intel8254_bus_master

Parameters
REQ-001 SETUP_CYC, 1, cycles with CS/address valid before strobe (legal range 1..15).
REQ-002 STROBE_CYC, 2, cycles rd_n/wr_n held low (legal range 1..15).
REQ-003 HOLD_CYC, 1, cycles with CS/address held after strobe release (legal range 1..15).

Interface
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  host command present.
REQ-007 req_ready  out  1  block can accept a command.
REQ-008 req_op  in  2  00 byte write, 01 byte read, 10 16-bit write (LSB then MSB), 11 latched 16-bit read.
REQ-009 req_addr  in  2  {A1,A0} target: 0..2 counters, 3 control register.
REQ-010 req_wdata  in  16  write data; byte write uses [7:0].
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  16  read result.
REQ-013 rsp_error  out  1  qualifies rsp_valid; command rejected.
REQ-014 cs_n, rd_n, wr_n  out  1 each  active-low chip bus strobes.
REQ-015 a1, a0  out  1 each  chip address.
REQ-016 data_out  out  8  byte driven to chip.
REQ-017 data_oe  out  1  data_out drive enable.
REQ-018 data_in  in  8  byte returned by chip.

Function
REQ-019 Command accepted when req_valid and req_ready both high on a rising edge; req_* captured then; req_ready high only in IDLE.
REQ-020 States: IDLE, SETUP, STROBE, HOLD, RECOVER, RESP; a per-state down-counter sets each dwell.
REQ-021 Each bus byte = SETUP_CYC SETUP + STROBE_CYC STROBE + HOLD_CYC HOLD + 1 RECOVER cycle; default 5 cycles.
REQ-022 cs_n low and a1/a0 stable from first SETUP through last HOLD cycle; high in RECOVER, IDLE, RESP.
REQ-023 wr_n (write byte) or rd_n (read byte) low in STROBE only; never both low together.
REQ-024 Write byte: data_oe high and data_out stable SETUP through HOLD; data_oe low elsewhere.
REQ-025 Read byte: data_in sampled on the last STROBE cycle; data_oe low throughout.
REQ-026 Op 10: byte0 = req_wdata[7:0], byte1 = req_wdata[15:8], both to req_addr.
REQ-027 Op 11: byte0 = counter-latch command to address 3, value {req_addr,6'b000000}; byte1 read LSB; byte2 read MSB; both reads from req_addr.
REQ-028 After RECOVER of a non-final byte, next byte's SETUP follows immediately; after the final byte, RESP for exactly one cycle, then IDLE.
REQ-029 rsp_valid high only in RESP; rsp_rdata: op 01 {8'h00,byte}, op 11 {MSB,LSB}, writes 16'h0000.
REQ-030 Error: op 01, 10 or 11 with req_addr=3 -> no bus cycle, RESP on the cycle after acceptance with rsp_error=1, rsp_rdata=0.
REQ-031 Op 00 with req_addr=3 is legal (control-word write).
REQ-032 rsp_rdata and rsp_error hold their values until the next RESP.
REQ-033 Latency from acceptance to rsp_valid: N*(S+T+H+1)+1 cycles, N = bytes; defaults 6 (1 byte), 11 (op 10), 16 (op 11).
REQ-034 req_valid while busy ignored; no queuing.

Reset
REQ-035 While rst high: state IDLE, req_ready=1, cs_n=rd_n=wr_n=1, a1=a0=0, data_out=0, data_oe=0, rsp_valid=0, rsp_error=0, rsp_rdata=0.
REQ-036 rst asserted mid-transaction releases all strobes asynchronously in the same cycle; the aborted command produces no response.
REQ-037 After rst deasserts, the first command is accepted on the first rising edge.

Verification
REQ-038 Op 00, addr 3, wdata 0x0034 -> cs_n low cycles 1-4, wr_n low cycles 2-3, data_out 0x34, rsp_valid cycle 6, rsp_error=0.
REQ-039 Op 10, addr 0, wdata 0x1234 -> two write bytes 0x34 then 0x12 to addr 0, cs_n high one cycle between, rsp_valid cycle 11.
REQ-040 Op 11, addr 2, chip model returns 0xCD then 0xAB -> control write 0x80 to addr 3, two reads from addr 2, rsp_rdata 0xABCD at cycle 16.
REQ-041 Op 01, addr 3 -> no strobe activity, rsp_valid and rsp_error high on the cycle after acceptance, rsp_rdata 0.
REQ-042 rst pulsed during STROBE of op 10 -> wr_n/cs_n high, data_oe low immediately, no rsp_valid, next op 00 completes normally.
REQ-043 req_valid held high continuously with SETUP_CYC=3, STROBE_CYC=4, HOLD_CYC=2 -> each accepted only when req_ready high, byte period 10 cycles, rd_n/wr_n never overlap.
